// File: rtl/gen_sel_op_stage_pkg.sv
// Shared encodings for the generate-selected operator stage: occupancy states
// and the lane positions inside the output bundle.
package gen_sel_op_stage_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Lane offsets in out_data, r1 lives in the LSBs
    localparam int R1 = 0;
    localparam int R2 = 1;
    localparam int R3 = 2;
    localparam int R4 = 3;

endpackage

// File: rtl/gen_sel_op_stage_lane_ops.sv
// Four lane operators, each chosen at elaboration from the P1..P3 constants.
// Purely combinational; no runtime operator select exists.
module gen_sel_lane_ops
    import gen_sel_op_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int P1    = 5,
    parameter int P2    = 10,
    parameter int P3    = 3
) (
    input  logic [WIDTH-1:0]                d,
    output logic [NUM_LANES-1:0][WIDTH-1:0] r
);

    localparam int              LO      = WIDTH / 2;
    localparam logic [WIDTH-1:0] LO_MASK = (WIDTH'(1) << LO) - WIDTH'(1);

    if (P1 + P2 > 12) begin : g_r1_inc
        assign r[R1] = d + WIDTH'(1);
    end else begin : g_r1_dec
        assign r[R1] = d - WIDTH'(1);
    end

    if ((P1 > 3) && (P2 < 15)) begin : g_r2_dbl
        assign r[R2] = d << 1;
    end else begin : g_r2_half
        assign r[R2] = d >> 1;
    end

    if (P2 % P1 == 0) begin : g_r3_clr
        assign r[R3] = d & ~LO_MASK;
    end else begin : g_r3_set
        assign r[R3] = d | LO_MASK;
    end

    if ((P1 * P3) < (P2 + P3)) begin : g_r4_inv
        assign r[R4] = ~d;
    end else begin : g_r4_pass
        assign r[R4] = d;
    end

endmodule

// File: rtl/gen_sel_op_stage.sv
// Operator stage: lanes computed on acceptance, buffered in a 2-entry FIFO,
// delivered in order over a valid/ready output with a transfer counter.
module gen_sel_op_stage
    import gen_sel_op_stage_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int P1    = 5,
    parameter int P2    = 10,
    parameter int P3    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [15:0]          xfer_count
);

    logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
    logic [1:0][4*WIDTH-1:0]         mem;
    logic [1:0]                      occ;
    logic                            wptr, rptr;
    logic                            push, pop;

    gen_sel_lane_ops #(
        .WIDTH (WIDTH),
        .P1    (P1),
        .P2    (P2),
        .P3    (P3)
    ) u_ops (
        .d (in_data),
        .r (lanes)
    );

    // Flags come from occupancy only, so they drop the moment reset asserts
    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem  <= '0;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= lanes;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= OCC_EMPTY;
        end else begin
            case (occ)
                OCC_EMPTY: if (push) occ <= OCC_ONE;
                OCC_ONE: begin
                    if (push && !pop)      occ <= OCC_FULL;
                    else if (pop && !push) occ <= OCC_EMPTY;
                end
                OCC_FULL:  if (pop) occ <= OCC_ONE;
                default:   occ <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   xfer_count <= 16'd0;
        else if (pop) xfer_count <= xfer_count + 16'd1;
    end

endmodule

// File: tb/tb_gen_sel_op_stage.sv
// Bench for gen_sel_op_stage: a default-parameter instance checked against a
// queue model every cycle, plus an overridden-parameter instance.
module tb_gen_sel_op_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] xfer_count;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
    logic [7:0]  in_data1 = '0;
    logic        in_ready1, out_valid1;
    logic [31:0] out_data1;
    logic [15:0] xfer_count1;

    int          compared = 0;
    int          mism = 0;
    int          q[$];
    logic [15:0] exp_xfer = 16'd0;
    logic [31:0] held;

    always #5 clk = ~clk;

    gen_sel_op_stage u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .xfer_count(xfer_count)
    );

    gen_sel_op_stage #(.WIDTH(8), .P1(2), .P2(3), .P3(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_data(out_data1), .xfer_count(xfer_count1)
    );

    // Expected bundle straight from the lane rules, in plain integer arithmetic
    function automatic logic [31:0] ref_bundle(int d, int p1, int p2, int p3);
        int r1, r2, r3, r4;
        r1 = (p1 + p2 > 12) ? (d + 1) % 256 : (d + 255) % 256;
        r2 = (p1 > 3 && p2 < 15) ? (d * 2) % 256 : d / 2;
        r3 = (p2 % p1 == 0) ? d - d % 16 : d - d % 16 + 15;
        r4 = (p1 * p3 < p2 + p3) ? 255 - d : d;
        return {r4[7:0], r3[7:0], r2[7:0], r1[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already set; checks, then advances one cycle
    task automatic tick();
        bit push, pop;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        if (q.size() != 0) chk("out_data", out_data, ref_bundle(q[0], 5, 10, 3));
        chk("xfer_count", {16'd0, xfer_count}, {16'd0, exp_xfer});
        push = in_valid && (q.size() < 2);
        pop  = (q.size() != 0) && out_ready;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            exp_xfer = exp_xfer + 16'd1;
        end
        if (push) q.push_back(int'(in_data));
        @(negedge clk);
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_xfer", {16'd0, xfer_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic default-parameter transaction, and the override instance
        in_valid = 1'b1; in_data = 8'd10; out_ready = 1'b1;
        in_valid1 = 1'b1; in_data1 = 8'd10;
        tick();
        in_valid = 1'b0;
        in_data1 = 8'd0;
        chk("dflt_valid", {31'd0, out_valid}, 32'd1);
        chk("dflt_bundle", out_data, 32'h0A_00_14_0B);
        chk("ovr_bundle10", out_data1, 32'hF5_0F_05_09);
        tick();
        in_valid1 = 1'b0;
        chk("dflt_xfer1", {16'd0, xfer_count}, 32'd1);
        chk("ovr_r1_zero", {24'd0, out_data1[7:0]}, 32'd255);
        chk("ovr_bundle0", out_data1, ref_bundle(0, 2, 3, 1));

        // Boundary operands at defaults
        in_valid = 1'b1; in_data = 8'd255;
        tick();
        in_valid = 1'b0;
        chk("r2_255", {24'd0, out_data[15:8]}, 32'd254);
        chk("r1_255", {24'd0, out_data[7:0]}, 32'd0);
        tick();

        // Backpressure: fill, hold the third operand, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd3;
        tick();
        in_data = 8'd4;
        tick();
        in_data = 8'd5;
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_stable", out_data, held);
        end
        out_ready = 1'b1;
        chk("stall_head3", out_data, ref_bundle(3, 5, 10, 3));
        tick();
        chk("drain_head4", out_data, ref_bundle(4, 5, 10, 3));
        tick();
        in_valid = 1'b0;
        chk("drain_head5", out_data, ref_bundle(5, 5, 10, 3));
        tick();
        tick();

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            tick();
        end

        // Reset while full: flags must drop with no clock edge
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_xfer", {16'd0, xfer_count}, 32'd0);
        q.delete();
        exp_xfer = 16'd0;
        out_ready = 1'b1; in_data = 8'd9;
        @(negedge clk);
        chk("rst_edge_no_xfer", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        in_data = 8'd77;
        tick();
        in_valid = 1'b0;
        chk("post_rst_first", out_data, ref_bundle(77, 5, 10, 3));
        tick();

        // Stream to the counter wrap
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 70000 && exp_xfer != 16'hFFFF; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        chk("xfer_at_max", {16'd0, xfer_count}, 32'h0000FFFF);
        tick();
        in_valid = 1'b0;
        chk("xfer_wrap", {16'd0, xfer_count}, 32'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule

// File: doc/gen_sel_op_stage.md
GEN_SEL_OP_STAGE -- requirements
Module: gen_sel_op_stage

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 8, lane data width in bits.
- P1, 5, selection constant 1.
- P2, 10, selection constant 2.
- P3, 3, selection constant 3.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock; all state on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream operand present.
- in_ready, output, 1, stage accepts operand this cycle.
- in_data, input, WIDTH, operand.
- out_valid, output, 1, result bundle present.
- out_ready, input, 1, downstream accepts bundle.
- out_data, output, 4*WIDTH, lanes {r4,r3,r2,r1}; r1 in the LSBs.
- xfer_count, output, 16, number of completed output transfers.

Function
REQ-003 Lane operators SHALL be fixed at elaboration by generate-if on parameter expressions; no runtime select.
- r1 = d+1 if (P1+P2 > 12), else d-1.
- r2 = d*2 if ((P1>3) && (P2<15)), else d/2.
- r3 = d & {WIDTH{1'b1}} with the low half cleared if (P2 % P1 == 0), else d with the low half set.
REQ-004 r4 = ~d if ((P1*P3) < (P2+P3)), else d.
REQ-005 All lane arithmetic SHALL be unsigned modulo 2^WIDTH; d/2 truncates; d-1 at d=0 wraps to all ones.
REQ-006 An input transfer SHALL occur on any clock edge where in_valid && in_ready.
REQ-007 An output transfer SHALL occur on any clock edge where out_valid && out_ready.
REQ-008 Each accepted operand SHALL be computed combinationally and written into a 2-entry FIFO.
REQ-009 The bundle SHALL be visible on out_data with out_valid=1 one cycle after acceptance; latency is 1 when the FIFO is empty.
REQ-010 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries, registered-free but independent of in_valid.
REQ-011 Output order SHALL equal input order.
REQ-012 Simultaneous input and output transfer with the FIFO full SHALL NOT be accepted on the input side (in_ready=0 when full); when 1 entry is held, a simultaneous transfer keeps occupancy at 1.
REQ-013 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-014 Read and write pointers SHALL be 1 bit each and wrap.
REQ-015 Occupancy SHALL be tracked in a 2-bit count in {0,1,2}, with states EMPTY, ONE, FULL:
- EMPTY -> ONE on input transfer.
- ONE -> FULL on input only; ONE -> EMPTY on output only; ONE stays ONE on both.
- FULL -> ONE on output transfer.
REQ-016 xfer_count SHALL increment on each output transfer and wrap from 16'hFFFF to 0.

Reset
REQ-017 Assertion of rst_n=0 SHALL immediately force: out_valid=0, in_ready=1, pointers=0, occupancy=EMPTY, xfer_count=0, out_data=0.
REQ-018 Reset mid-operation SHALL discard all buffered bundles; no transfer completes on the edge where rst_n is low.
REQ-019 Reset release SHALL be synchronised by the integrating design; the block's first transfer may occur on the first edge after release.

Structure
REQ-020 A shared package SHALL hold the occupancy state encoding and the lane-index constants (R1..R4 offsets).
REQ-021 One sub-module, gen_sel_lane_ops (purely the four generate-selected operators), SHALL be instantiated; the FIFO and counter SHALL live in the top.

Verification
REQ-022 Default parameters, in_data=10, out_ready=1 -> one cycle later out_valid=1 and r1=11, r2=20, r3=8'h00, r4=10; xfer_count=1.
REQ-023 Override P1=2, P2=3, P3=1 -> in_data=10 gives r1=9, r2=5, r3=8'h0F, r4=8'hF5.
REQ-024 out_ready=0, push 3,4,5 on consecutive cycles -> in_ready low after 2nd accept; 5 is held by upstream; release delivers 3,4,5 in order with no data change while stalled.
REQ-025 in_data=0 and 255 at defaults -> r1 of 0 path checked with P1+P2<=12 override gives 255; r2 for 255 at defaults gives 254.
REQ-026 Force xfer_count near wrap (65535 transfers) -> next transfer gives 0.
REQ-027 Assert rst_n low while FULL -> out_valid drops without a clock edge; after release, next output is the first post-reset input.
